sdf_output_reorder: RTL and testbench

//   Output end of the radix-2 SDF FFT pipeline: accepts the complex sample stream leaving
//   the last bf_stage, which arrives in bit-reversed index order, and re-emits each frame of
//   2^N samples in natural index order (0..2^N-1).

---
 rtl/sdf_output_reorder_pkg.sv | 37 +++
 rtl/sdf_output_reorder_bank.sv | 39 +++
 rtl/sdf_output_reorder.sv | 136 +++++++++++++
 tb/tb_sdf_output_reorder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdf_output_reorder_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared FFT helpers: the bit-reversal index permutation and the frame-length
//   helper. The same permutation serves the input-side shuffle and the output
//   reorder, so it lives here once.
//   Contents:
//     MAX_N      widest index bitrev() handles
//     FFT_N      default log2 frame length of the pipeline
//     FRAME_LEN  default frame length (1 << FFT_N)
//     frame_len  frame length for a given log2 size
//     bitrev     reverse the low n bits of an index (upper bits return 0)
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int MAX_N     = 16;
    localparam int FFT_N     = 3;
    localparam int FRAME_LEN = 1 << FFT_N;

    function automatic int frame_len(input int n);
        return 1 << n;
    endfunction

    // Bit i of the result takes bit n-1-i of the index. Callers size-cast the
    // argument up to MAX_N and the result back down to their own N.
    function automatic logic [MAX_N-1:0] bitrev(input logic [MAX_N-1:0] idx,
                                                input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                r[i] = idx[n-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdf_output_reorder_bank.sv
// -----------------------------------------------------------------------------
// reorder_bank
//   One frame of sample storage: 2^N words of 2W bits. Synchronous write,
//   asynchronous read. Contents are not reset.
//   Ports:
//     clk      rising-edge clock
//     we_i     write enable
//     waddr_i  write address
//     wdata_i  write data {real, imag}
//     raddr_i  read address
//     rdata_o  read data {real, imag}, combinational from raddr_i
// -----------------------------------------------------------------------------
module reorder_bank
    import fft_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           we_i,
    input  logic [N-1:0]   waddr_i,
    input  logic [2*W-1:0] wdata_i,
    input  logic [N-1:0]   raddr_i,
    output logic [2*W-1:0] rdata_o
);

    localparam int DEPTH = frame_len(N);

    logic [2*W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sdf_output_reorder.sv
// -----------------------------------------------------------------------------
// sdf_output_reorder
//   Output end of the radix-2 SDF FFT pipeline. Takes the bit-reversed sample
//   stream from the last butterfly stage and re-emits each 2^N-sample frame in
//   natural index order. Two banks ping-pong so one frame fills while the other
//   drains, giving a sustained rate of one sample per clock.
//
//   Handshake: a sample moves across a port in any cycle where valid and ready
//   are both high at the rising clock edge. ip_ready depends only on internal
//   state, never on ip_valid. While op_valid is high and op_ready low, op_valid
//   and the output data hold steady.
//
//   Ports:
//     clk, rst            clock; synchronous active-high reset
//     ip_valid/ip_ready   input handshake
//     ip_real/ip_img      input sample, bit-reversed order
//     op_valid/op_ready   output handshake
//     op_real/op_img      output sample, natural order (0 when !op_valid)
//     op_first/op_last    frame markers, present only when
//                         REORDER_FRAME_MARK_EN is defined
// -----------------------------------------------------------------------------
module sdf_output_reorder
    import fft_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ip_valid,
    output logic         ip_ready,
    input  logic [W-1:0] ip_real,
    input  logic [W-1:0] ip_img,
    output logic         op_valid,
    input  logic         op_ready,
    output logic [W-1:0] op_real,
    output logic [W-1:0] op_img
`ifdef REORDER_FRAME_MARK_EN
    ,
    output logic         op_first,
    output logic         op_last
`endif
);

    localparam logic [N-1:0] CNT_MAX = '1;

    logic [1:0]     full_q, full_d;
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [N-1:0]   wr_cnt_q, wr_cnt_d;
    logic [N-1:0]   rd_cnt_q, rd_cnt_d;

    logic           accept;
    logic           xfer;
    logic [N-1:0]   wr_addr;
    logic [2*W-1:0] wdata;
    logic [2*W-1:0] rdata0, rdata1, rdata;

    assign ip_ready = !full_q[wr_bank_q];
    assign op_valid = full_q[rd_bank_q];
    assign accept   = ip_valid && ip_ready;
    assign xfer     = op_valid && op_ready;

    // The k-th sample of a frame carries natural index bitrev(k), so storing
    // it there lets the read side walk addresses 0..2^N-1 in order.
    assign wr_addr  = N'(bitrev(MAX_N'(wr_cnt_q), N));
    assign wdata    = {ip_real, ip_img};

    reorder_bank #(.N(N), .W(W)) u_bank0 (
        .clk     (clk),
        .we_i    (accept && !wr_bank_q),
        .waddr_i (wr_addr),
        .wdata_i (wdata),
        .raddr_i (rd_cnt_q),
        .rdata_o (rdata0)
    );

    reorder_bank #(.N(N), .W(W)) u_bank1 (
        .clk     (clk),
        .we_i    (accept && wr_bank_q),
        .waddr_i (wr_addr),
        .wdata_i (wdata),
        .raddr_i (rd_cnt_q),
        .rdata_o (rdata1)
    );

    assign rdata   = rd_bank_q ? rdata1 : rdata0;
    assign op_real = op_valid ? rdata[2*W-1:W] : '0;
    assign op_img  = op_valid ? rdata[W-1:0]   : '0;

`ifdef REORDER_FRAME_MARK_EN
    assign op_first = op_valid && (rd_cnt_q == '0);
    assign op_last  = op_valid && (rd_cnt_q == CNT_MAX);
`endif

    // A write only targets a non-full bank and a read only a full one, so the
    // two flag updates below always touch different bits and both apply.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        if (accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == CNT_MAX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (xfer) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == CNT_MAX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

endmodule

// File: tb/tb_sdf_output_reorder.sv
// -----------------------------------------------------------------------------
// tb_sdf_output_reorder
//   Self-checking bench for sdf_output_reorder (N=3, W=16). The reference model
//   collects each complete input frame and places its k-th sample at natural
//   index bitrev(k), then queues the frame in index order. Build with
//   REORDER_FRAME_MARK_EN defined to also check op_first/op_last.
// -----------------------------------------------------------------------------
module tb_sdf_output_reorder;

    localparam int TB_N  = 3;
    localparam int TB_W  = 16;
    localparam int FRAME = 1 << TB_N;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ip_valid = 1'b0;
    logic            ip_ready;
    logic [TB_W-1:0] ip_real = '0;
    logic [TB_W-1:0] ip_img = '0;
    logic            op_valid;
    logic            op_ready = 1'b0;
    logic [TB_W-1:0] op_real;
    logic [TB_W-1:0] op_img;
`ifdef REORDER_FRAME_MARK_EN
    logic            op_first;
    logic            op_last;
`endif

    always #5 clk = ~clk;

    sdf_output_reorder #(.N(TB_N), .W(TB_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ip_valid (ip_valid),
        .ip_ready (ip_ready),
        .ip_real  (ip_real),
        .ip_img   (ip_img),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_real  (op_real),
        .op_img   (op_img)
`ifdef REORDER_FRAME_MARK_EN
        ,
        .op_first (op_first),
        .op_last  (op_last)
`endif
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    logic [2*TB_W-1:0] exp_q[$];
    logic [2*TB_W-1:0] in_q[$];
    int mark_idx = 0;
    logic mk_first, mk_last;

    function automatic int ref_bitrev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < TB_N; b++) begin
            if (k[b]) r = r | (1 << (TB_N - 1 - b));
        end
        return r;
    endfunction

    function automatic void model_push(input logic [TB_W-1:0] re, input logic [TB_W-1:0] im);
        logic [2*TB_W-1:0] frame [FRAME];
        in_q.push_back({re, im});
        if (in_q.size() == FRAME) begin
            for (int k = 0; k < FRAME; k++) frame[ref_bitrev(k)] = in_q[k];
            for (int n = 0; n < FRAME; n++) exp_q.push_back(frame[n]);
            in_q.delete();
        end
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; drives one cycle and samples at the
    // falling edge what will transfer on the next rising edge.
    task automatic drive_cycle(input logic iv, input logic [TB_W-1:0] re,
                               input logic [TB_W-1:0] im, input logic ordy,
                               output logic acc, output logic xf, output logic ov,
                               output logic [TB_W-1:0] ore, output logic [TB_W-1:0] oim);
        ip_valid = iv;
        ip_real  = re;
        ip_img   = im;
        op_ready = ordy;
        @(negedge clk);
        acc = iv && ip_ready;
        xf  = op_valid && ordy;
        ov  = op_valid;
        ore = op_real;
        oim = op_img;
`ifdef REORDER_FRAME_MARK_EN
        mk_first = op_first;
        mk_last  = op_last;
`else
        mk_first = 1'b0;
        mk_last  = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        ip_valid = 1'b0;
        op_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ip_ready !== 1'b1) begin errors++; $display("FAIL reset_ip_ready: got %b want 1", ip_ready); end
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
        checks++; if (op_real !== '0) begin errors++; $display("FAIL reset_op_real: got %h want 0", op_real); end
        checks++; if (op_img !== '0) begin errors++; $display("FAIL reset_op_img: got %h want 0", op_img); end
`ifdef REORDER_FRAME_MARK_EN
        checks++; if ({op_first, op_last} !== 2'b00) begin errors++; $display("FAIL reset_marks: got %b want 00", {op_first, op_last}); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        mark_idx = 0;
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic test_one_frame();
        int seq [FRAME] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int n_acc = 0, n_out = 0, cyc = 0, acc_cyc = -1, first_cyc = -1, early = 0;
        logic acc, xf, ov;
        logic [TB_W-1:0] ore, oim, re;
        while (n_out < FRAME && cyc < 100) begin
            re = (n_acc < FRAME) ? TB_W'(seq[n_acc]) : '0;
            drive_cycle(n_acc < FRAME, re, -re, 1'b1, acc, xf, ov, ore, oim);
            if (ov && first_cyc < 0) first_cyc = cyc;
            if (ov && n_acc < FRAME) early++;
            if (xf) begin
                checks++;
                if (ore !== TB_W'(n_out) || oim !== TB_W'(-n_out)) begin
                    errors++;
                    $display("FAIL one_frame_data[%0d]: got %0d/%0d want %0d/%0d", n_out,
                             $signed(ore), $signed(oim), n_out, -n_out);
                end
                n_out++;
                mark_idx++;
            end
            if (acc) begin
                n_acc++;
                if (n_acc == FRAME) acc_cyc = cyc;
            end
            cyc++;
        end
        checks++; if (n_out != FRAME) begin errors++; $display("FAIL one_frame_count: got %0d want %0d", n_out, FRAME); end
        checks++; if (early != 0) begin errors++; $display("FAIL one_frame_early_valid: got %0d want 0", early); end
        checks++; if (first_cyc != acc_cyc + 1) begin errors++; $display("FAIL one_frame_latency: got cycle %0d want %0d", first_cyc, acc_cyc + 1); end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0, n_out = 0, cyc = 0, stalls = 0, first_cyc = -1, last_cyc = -1;
        logic acc, xf, ov;
        logic [TB_W-1:0] ore, oim, re, im;
        logic [2*TB_W-1:0] exp;
        while (n_out < 3 * FRAME && cyc < 200) begin
            re = TB_W'($urandom);
            im = TB_W'($urandom);
            drive_cycle(n_acc < 3 * FRAME, re, im, 1'b1, acc, xf, ov, ore, oim);
            if (n_acc < 3 * FRAME && !acc) stalls++;
            if (acc) begin model_push(re, im); n_acc++; end
            if (xf) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_data: got unexpected %h%h want none", ore, oim);
                end else begin
                    exp = exp_q.pop_front();
                    if ({ore, oim} !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", n_out, {ore, oim}, exp); end
                end
`ifdef REORDER_FRAME_MARK_EN
                checks++;
                if (mk_first !== (mark_idx % FRAME == 0) || mk_last !== (mark_idx % FRAME == FRAME - 1)) begin
                    errors++; $display("FAIL b2b_marks[%0d]: got %b%b", mark_idx, mk_first, mk_last);
                end
`endif
                mark_idx++;
                n_out++;
            end
            cyc++;
        end
        checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_ip_ready: got %0d stalls want 0", stalls); end
        checks++; if (n_out != 3 * FRAME) begin errors++; $display("FAIL b2b_count: got %0d want %0d", n_out, 3 * FRAME); end
        checks++; if (last_cyc - first_cyc != 3 * FRAME - 1) begin errors++; $display("FAIL b2b_gaps: got span %0d want %0d", last_cyc - first_cyc, 3 * FRAME - 1); end
    endtask

    task automatic test_backpressure();
        int n_acc = 0, n_out = 0, cyc = 0;
        logic acc, xf, ov;
        logic [TB_W-1:0] ore, oim, re, im;
        logic [2*TB_W-1:0] exp;
        for (int i = 0; i < 3 * FRAME; i++) begin
            re = TB_W'($urandom);
            im = TB_W'($urandom);
            drive_cycle(1'b1, re, im, 1'b0, acc, xf, ov, ore, oim);
            if (acc) begin model_push(re, im); n_acc++; end
        end
        ip_valid = 1'b0;
        checks++; if (n_acc != 2 * FRAME) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", n_acc, 2 * FRAME); end
        checks++; if (ip_ready !== 1'b0) begin errors++; $display("FAIL bp_ip_ready_low: got %b want 0", ip_ready); end
        while (n_out < 2 * FRAME && cyc < 100) begin
            drive_cycle(1'b0, '0, '0, 1'b1, acc, xf, ov, ore, oim);
            if (xf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_data: got unexpected %h%h want none", ore, oim);
                end else begin
                    exp = exp_q.pop_front();
                    if ({ore, oim} !== exp) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", n_out, {ore, oim}, exp); end
                end
                mark_idx++;
                n_out++;
            end
            cyc++;
        end
        checks++; if (n_out != 2 * FRAME) begin errors++; $display("FAIL bp_count: got %0d want %0d", n_out, 2 * FRAME); end
        checks++; if (ip_ready !== 1'b1) begin errors++; $display("FAIL bp_ip_ready_back: got %b want 1", ip_ready); end
    endtask

    task automatic test_random();
        int n_acc = 0, n_out = 0, cyc = 0, total;
        logic acc, xf, ov, iv, ordy, hold;
        logic [TB_W-1:0] ore, oim, re, im;
        logic [2*TB_W-1:0] exp, hold_data;
        total = 20 * FRAME;
        hold = 1'b0;
        hold_data = '0;
        while ((n_acc < total || exp_q.size() > 0) && cyc < 3000) begin
            iv   = (n_acc < total) ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = 1'($urandom_range(0, 1));
            re   = TB_W'($urandom);
            im   = TB_W'($urandom);
            drive_cycle(iv, re, im, ordy, acc, xf, ov, ore, oim);
            if (hold) begin
                checks++;
                if (!ov || {ore, oim} !== hold_data) begin
                    errors++; $display("FAIL rand_stable: got %b/%h want 1/%h", ov, {ore, oim}, hold_data);
                end
            end
            hold = ov && !ordy;
            hold_data = {ore, oim};
            if (acc) begin model_push(re, im); n_acc++; end
            if (xf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_data: got unexpected %h%h want none", ore, oim);
                end else begin
                    exp = exp_q.pop_front();
                    if ({ore, oim} !== exp) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", n_out, {ore, oim}, exp); end
                end
`ifdef REORDER_FRAME_MARK_EN
                checks++;
                if (mk_first !== (mark_idx % FRAME == 0) || mk_last !== (mark_idx % FRAME == FRAME - 1)) begin
                    errors++; $display("FAIL rand_marks[%0d]: got %b%b", mark_idx, mk_first, mk_last);
                end
`endif
                mark_idx++;
                n_out++;
            end
            cyc++;
        end
        checks++; if (n_acc != total) begin errors++; $display("FAIL rand_accepted: got %0d want %0d", n_acc, total); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drained: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int n_acc = 0, n_out = 0, cyc = 0;
        logic acc, xf, ov;
        logic [TB_W-1:0] ore, oim, re, im;
        logic [2*TB_W-1:0] exp;
        while (n_acc < 5 && cyc < 50) begin
            re = TB_W'($urandom);
            im = TB_W'($urandom);
            drive_cycle(1'b1, re, im, 1'b1, acc, xf, ov, ore, oim);
            if (acc) begin model_push(re, im); n_acc++; end
            cyc++;
        end
        rst = 1'b1;
        ip_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (op_valid !== 1'b0 || op_real !== '0 || op_img !== '0) begin
                errors++; $display("FAIL rst_outputs: got %b/%h/%h want 0/0/0", op_valid, op_real, op_img);
            end
`ifdef REORDER_FRAME_MARK_EN
            checks++; if ({op_first, op_last} !== 2'b00) begin errors++; $display("FAIL rst_marks: got %b want 00", {op_first, op_last}); end
`endif
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        in_q.delete();
        mark_idx = 0;
        n_acc = 0;
        cyc = 0;
        while (n_out < FRAME && cyc < 100) begin
            re = TB_W'($urandom);
            im = TB_W'($urandom);
            drive_cycle(n_acc < FRAME, re, im, 1'b1, acc, xf, ov, ore, oim);
            if (acc) begin model_push(re, im); n_acc++; end
            if (xf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rst_fresh_data: got unexpected %h%h want none", ore, oim);
                end else begin
                    exp = exp_q.pop_front();
                    if ({ore, oim} !== exp) begin errors++; $display("FAIL rst_fresh_data[%0d]: got %h want %h", n_out, {ore, oim}, exp); end
                end
                mark_idx++;
                n_out++;
            end
            cyc++;
        end
        checks++; if (n_out != FRAME) begin errors++; $display("FAIL rst_fresh_count: got %0d want %0d", n_out, FRAME); end
        repeat (3) drive_cycle(1'b0, '0, '0, 1'b1, acc, xf, ov, ore, oim);
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rst_no_leak: got op_valid %b want 0", op_valid); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_one_frame();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
